// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared definitions for the arbitrated binary->BCD converter: FSM states,
// BCD constants and elaboration-time helper functions.
package bcd_conv_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Requester-index width; a single requester still gets a 1-bit index.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest value representable in d decades: 10^d - 1.
  function automatic longint unsigned decade_limit(input int unsigned d);
    longint unsigned v;
    v = 1;
    for (int unsigned i = 0; i < d; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_dabble_core.sv
// Iterative double-dabble engine: loads an operand on i_start, then performs
// one add-3/shift step per CE cycle for IN_BITS_NUM cycles.
module bcd_dabble_core #(
  parameter int unsigned IN_BITS_NUM = 7,
  parameter int unsigned OUT_DECADES = 2
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     CE,
  input  logic                     i_start,
  input  logic [IN_BITS_NUM-1:0]   i_din,
  output logic                     o_done,
  output logic [OUT_DECADES*4-1:0] o_bcd
);

  localparam int unsigned BCD_W = OUT_DECADES * 4;
  localparam int unsigned SR_W  = BCD_W + IN_BITS_NUM;
  localparam int unsigned CNT_W = $clog2(IN_BITS_NUM + 1);

  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_adj;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_adj = r_sr;
    for (int unsigned d = 0; d < OUT_DECADES; d++) begin
      if (r_sr[IN_BITS_NUM + 4*d +: 4] >= 4'd5)
        w_adj[IN_BITS_NUM + 4*d +: 4] = r_sr[IN_BITS_NUM + 4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (CE) begin
      if (i_start) begin
        r_sr  <= {{BCD_W{1'b0}}, i_din};
        r_cnt <= CNT_W'(IN_BITS_NUM);
      end else if (r_cnt != '0) begin
        r_sr  <= {w_adj[SR_W-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // High while the final step is pending, so the caller can advance on the same edge.
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one double-dabble engine among NUM_REQ requesters;
// returns a tagged BCD result with an overflow flag.
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned IN_BITS_NUM = 7,
  parameter int unsigned OUT_DECADES = 2
) (
  input  logic                             CLK,
  input  logic                             CLR,
  input  logic                             CE,
  input  logic [NUM_REQ-1:0]               REQ,
  input  logic [NUM_REQ*IN_BITS_NUM-1:0]   IN_BUS,
  output logic [NUM_REQ-1:0]               ACK,
  output logic                             BUSY,
  output logic                             VALID,
  output logic [OUT_DECADES*4-1:0]         Q,
  output logic [id_width(NUM_REQ)-1:0]     Q_ID,
  output logic                             OVF
);

  localparam int unsigned     ID_W  = id_width(NUM_REQ);
  localparam longint unsigned LIMIT = decade_limit(OUT_DECADES);

  state_t                   r_state, w_state_nxt;
  logic [ID_W-1:0]          r_ptr, r_gnt;
  logic                     r_ovf_pend;
  logic [NUM_REQ-1:0]       r_ack;
  logic                     r_valid, r_ovf;
  logic [OUT_DECADES*4-1:0] r_q;
  logic [ID_W-1:0]          r_q_id;

  logic                     w_any, w_lo_found, w_hi_found, w_start, w_ovf, w_core_done;
  logic [ID_W-1:0]          w_lo, w_hi, w_gnt;
  logic [IN_BITS_NUM-1:0]   w_operand;
  logic [OUT_DECADES*4-1:0] w_bcd;

  // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    w_lo       = '0;
    w_hi       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (REQ[i]) begin
        if (!w_lo_found) begin
          w_lo       = ID_W'(i);
          w_lo_found = 1'b1;
        end
        if (!w_hi_found && (ID_W'(i) >= r_ptr)) begin
          w_hi       = ID_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_any = w_lo_found;
    w_gnt = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_operand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) w_operand = IN_BUS[i*IN_BITS_NUM +: IN_BITS_NUM];
    end
  end

  assign w_ovf   = (64'(w_operand) > LIMIT);
  assign w_start = (r_state == ST_IDLE) && w_any;

  bcd_dabble_core #(
    .IN_BITS_NUM (IN_BITS_NUM),
    .OUT_DECADES (OUT_DECADES)
  ) u_core (
    .CLK     (CLK),
    .CLR     (CLR),
    .CE      (CE),
    .i_start (w_start),
    .i_din   (w_operand),
    .o_done  (w_core_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)     r_state <= ST_IDLE;
    else if (CE) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_core_done) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_ack      <= '0;
      r_valid    <= 1'b0;
      r_q        <= '0;
      r_q_id     <= '0;
      r_ovf      <= 1'b0;
    end else if (CE) begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ack      <= NUM_REQ'(1) << w_gnt;
            r_gnt      <= w_gnt;
            r_ovf_pend <= w_ovf;
          end
        end
        ST_DONE: begin
          r_q     <= r_ovf_pend ? {OUT_DECADES{BCD_NINE}} : w_bcd;
          r_q_id  <= r_gnt;
          r_ovf   <= r_ovf_pend;
          r_valid <= 1'b1;
          r_ptr   <= (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ACK   = r_ack;
  assign BUSY  = (r_state != ST_IDLE);
  assign VALID = r_valid;
  assign Q     = r_q;
  assign Q_ID  = r_q_id;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter (2 requesters, 7-bit operands, 2 decades).
module tb_bcd_conv_arbiter;

  logic       CLK, CLR, CE;
  logic [1:0] REQ;
  logic [13:0] IN_BUS;
  logic [1:0] ACK;
  logic       BUSY, VALID, OVF;
  logic [7:0] Q;
  logic [0:0] Q_ID;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bcd_conv_arbiter #(
    .NUM_REQ     (2),
    .IN_BITS_NUM (7),
    .OUT_DECADES (2)
  ) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .CE     (CE),
    .REQ    (REQ),
    .IN_BUS (IN_BUS),
    .ACK    (ACK),
    .BUSY   (BUSY),
    .VALID  (VALID),
    .Q      (Q),
    .Q_ID   (Q_ID),
    .OVF    (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] req;
    logic [6:0] in0;
    logic [6:0] in1;
    logic [7:0] q;
    logic       id;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output int unsigned n);
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      step();
      n++;
      if (VALID) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout actual=no_valid expected=valid", name);
    end
  endtask

  int unsigned n;
  logic [1:0]  ack_log[$];
  int unsigned ack_cyc[$];
  logic [7:0]  q_log[$];
  logic        id_log[$];

  initial begin
    vecs[0] = '{req: 2'b01, in0: 7'd59,  in1: 7'd0,  q: 8'h59, id: 1'b0, ovf: 1'b0};
    vecs[1] = '{req: 2'b01, in0: 7'd0,   in1: 7'd0,  q: 8'h00, id: 1'b0, ovf: 1'b0};
    vecs[2] = '{req: 2'b01, in0: 7'd99,  in1: 7'd0,  q: 8'h99, id: 1'b0, ovf: 1'b0};
    vecs[3] = '{req: 2'b01, in0: 7'd100, in1: 7'd0,  q: 8'h99, id: 1'b0, ovf: 1'b1};
    vecs[4] = '{req: 2'b01, in0: 7'd127, in1: 7'd0,  q: 8'h99, id: 1'b0, ovf: 1'b1};
    vecs[5] = '{req: 2'b10, in0: 7'd0,   in1: 7'd34, q: 8'h34, id: 1'b1, ovf: 1'b0};
    vecs[6] = '{req: 2'b10, in0: 7'd0,   in1: 7'd9,  q: 8'h09, id: 1'b1, ovf: 1'b0};

    CLR = 1'b1; CE = 1'b1; REQ = '0; IN_BUS = '0;
    #12;
    chk("rst_ack",   32'(ACK),   32'h0);
    chk("rst_valid", 32'(VALID), 32'h0);
    chk("rst_busy",  32'(BUSY),  32'h0);
    chk("rst_q",     32'(Q),     32'h0);
    chk("rst_qid",   32'(Q_ID),  32'h0);
    chk("rst_ovf",   32'(OVF),   32'h0);
    step();
    CLR = 1'b0;
    step();

    // Single-requester table: grant, latency, result, pulse widths.
    for (int unsigned v = 0; v < 7; v++) begin
      REQ    = vecs[v].req;
      IN_BUS = {vecs[v].in1, vecs[v].in0};
      step();
      chk($sformatf("v%0d_ack", v),  32'(ACK),  32'(vecs[v].req));
      chk($sformatf("v%0d_busy", v), 32'(BUSY), 32'h1);
      REQ = '0;
      wait_valid($sformatf("v%0d_valid", v), n);
      chk($sformatf("v%0d_latency", v), n, 32'd8);
      chk($sformatf("v%0d_q", v),   32'(Q),    32'(vecs[v].q));
      chk($sformatf("v%0d_qid", v), 32'(Q_ID), 32'(vecs[v].id));
      chk($sformatf("v%0d_ovf", v), 32'(OVF),  32'(vecs[v].ovf));
      step();
      chk($sformatf("v%0d_valid_pulse", v), 32'(VALID), 32'h0);
      chk($sformatf("v%0d_idle", v),        32'(BUSY),  32'h0);
    end

    // Both requesting continuously: strict alternation, 9 cycles apart.
    REQ    = 2'b11;
    IN_BUS = {7'd34, 7'd12};
    for (int unsigned c = 1; c <= 36; c++) begin
      step();
      if (ACK != '0) begin
        ack_log.push_back(ACK);
        ack_cyc.push_back(c);
      end
      if (VALID) begin
        q_log.push_back(Q);
        id_log.push_back(Q_ID[0]);
      end
    end
    REQ = '0;
    chk("rr_ack_count",   ack_log.size(), 32'd4);
    chk("rr_valid_count", q_log.size(),   32'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < ack_log.size()) begin
        chk($sformatf("rr_ack%0d", i), 32'(ack_log[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("rr_cyc%0d", i), ack_cyc[i], 1 + 9 * i);
      end
      if (i < q_log.size()) begin
        chk($sformatf("rr_q%0d", i),   32'(q_log[i]),  (i % 2 == 0) ? 32'h12 : 32'h34);
        chk($sformatf("rr_qid%0d", i), 32'(id_log[i]), (i % 2 == 0) ? 32'h0 : 32'h1);
      end
    end
    step();
    chk("rr_no_regrant", 32'(ACK), 32'h0);

    // CE low for 3 cycles mid-shift delays VALID by exactly 3.
    REQ    = 2'b01;
    IN_BUS = {7'd0, 7'd47};
    step();
    chk("ce_ack", 32'(ACK), 32'h1);
    REQ = '0;
    step(); step(); step();
    CE = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ce_frz_valid%0d", i), 32'(VALID), 32'h0);
      chk($sformatf("ce_frz_busy%0d", i),  32'(BUSY),  32'h1);
    end
    CE = 1'b1;
    wait_valid("ce_valid", n);
    chk("ce_latency", n, 32'd5);
    chk("ce_q",       32'(Q), 32'h47);
    CE = 1'b0;
    step();
    chk("ce_valid_held", 32'(VALID), 32'h1);
    CE = 1'b1;
    step();
    chk("ce_valid_drop", 32'(VALID), 32'h0);

    // Asynchronous clear mid-shift with the request still held.
    REQ    = 2'b01;
    IN_BUS = {7'd0, 7'd73};
    step();
    chk("clr_ack0", 32'(ACK), 32'h1);
    step(); step(); step();
    CLR = 1'b1;
    #1;
    chk("clr_busy",  32'(BUSY),  32'h0);
    chk("clr_valid", 32'(VALID), 32'h0);
    chk("clr_q",     32'(Q),     32'h0);
    chk("clr_ovf",   32'(OVF),   32'h0);
    chk("clr_ack",   32'(ACK),   32'h0);
    step();
    chk("clr_hold_valid", 32'(VALID), 32'h0);
    CLR = 1'b0;
    step();
    chk("clr_regrant", 32'(ACK), 32'h1);
    REQ = '0;
    wait_valid("clr_valid_after", n);
    chk("clr_latency", n, 32'd8);
    chk("clr_result",  32'(Q), 32'h73);
    step();

    // Operand changes after ACK; captured value must be used.
    REQ    = 2'b01;
    IN_BUS = {7'd0, 7'd25};
    step();
    chk("cap_ack", 32'(ACK), 32'h1);
    REQ    = '0;
    IN_BUS = {7'd0, 7'd88};
    wait_valid("cap_valid", n);
    chk("cap_q",   32'(Q),    32'h25);
    chk("cap_qid", 32'(Q_ID), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
